// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte SPI mode 0 master with registered SPI outputs
module spi_master #(
  parameter int CLK_DIV  = 3,
  parameter int CS_SETUP = 1,
  parameter int CS_IDLE  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       CS_n,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    GAP
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_shift;

  // Transfer sequencer: every SPI pin and handshake output is a register written here
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      tx_ready <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      CS_n     <= 1'b1;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            // MSB goes out together with CS_n so it is stable before the first rising SCLK
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            tx_shift <= tx_data;
            MOSI     <= tx_data[7];
            CS_n     <= 1'b0;
            bit_cnt  <= '0;
            cnt      <= '0;
            rx_shift <= '0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= LOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        LOW: begin
          if (cnt == HALF_LAST) begin
            // Mode 0: slave data is sampled on the rising SCLK edge
            cnt      <= '0;
            SCLK     <= 1'b1;
            rx_shift <= {rx_shift[6:0], MISO};
            state    <= HIGH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt  <= '0;
            SCLK <= 1'b0;
            if (bit_cnt != 3'd7) begin
              // Next bit is launched on the falling edge, never while SCLK is high
              bit_cnt  <= bit_cnt + 3'd1;
              tx_shift <= {tx_shift[6:0], 1'b0};
              MOSI     <= tx_shift[6];
              state    <= LOW;
            end else begin
              CS_n     <= 1'b1;
              MOSI     <= 1'b0;
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              state    <= GAP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        GAP: begin
          if (cnt == IDLE_LAST) begin
            // Raising tx_ready here makes the next accept land CS_IDLE+1 cycles after CS_n rises
            cnt      <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       miso;

  logic [7:0] tx_data_b;
  logic       tx_valid_b;
  logic       tx_ready_b;
  logic [7:0] rx_data_b;
  logic       rx_valid_b;
  logic       busy_b;
  logic       cs_n_b;
  logic       sclk_b;
  logic       mosi_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  spi_master dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .CS_n     (cs_n),
    .SCLK     (sclk),
    .MOSI     (mosi),
    .MISO     (miso)
  );

  spi_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_IDLE(5)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data_b),
    .tx_valid (tx_valid_b),
    .tx_ready (tx_ready_b),
    .rx_data  (rx_data_b),
    .rx_valid (rx_valid_b),
    .busy     (busy_b),
    .CS_n     (cs_n_b),
    .SCLK     (sclk_b),
    .MOSI     (mosi_b),
    .MISO     (mosi_b)
  );

  // Behavioural slave: mode 0 loopback, 1 shifts out preset, 2 echoes the previous byte
  int         mode = 0;
  logic [7:0] preset = 8'h00;
  logic [7:0] echo_reg;
  logic [7:0] slv_rx;
  logic [3:0] k;
  logic       sclk_d;
  logic       cs_d;
  logic [7:0] src;

  always @(posedge clk) begin
    if (!rst) begin
      k        <= 4'd0;
      echo_reg <= 8'h00;
      slv_rx   <= 8'h00;
      sclk_d   <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      sclk_d <= sclk;
      cs_d   <= cs_n;
      if (cs_n) k <= 4'd0;
      else if (sclk && !sclk_d) begin
        k      <= k + 4'd1;
        slv_rx <= {slv_rx[6:0], mosi};
      end
      if (cs_n && !cs_d) echo_reg <= slv_rx;
    end
  end

  always_comb begin
    src  = (mode == 2) ? echo_reg : preset;
    miso = 1'b0;
    if (mode == 0) miso = mosi;
    else if (k < 4'd8) miso = src[3'd7 - k[2:0]];
  end

  // Bus monitor sampled on the falling clk edge
  int         cur_low = 0, last_low = 0, cur_rises = 0, last_rises = 0;
  int         high_run = 0, last_high = 0, cs_falls = 0, rxv_count = 0;
  int         mosi_viol = 0, ready_viol = 0;
  logic [7:0] cur_bits = 8'h00, last_bits = 8'h00;
  logic       p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;

  always @(negedge clk) begin
    if (!cs_n && p_cs) begin
      cs_falls  <= cs_falls + 1;
      last_high <= high_run;
      high_run  <= 0;
      cur_low   <= 1;
      cur_rises <= 0;
      cur_bits  <= 8'h00;
    end else if (!cs_n) begin
      cur_low <= cur_low + 1;
      if (sclk && !p_sclk) begin
        cur_rises <= cur_rises + 1;
        cur_bits  <= {cur_bits[6:0], mosi};
      end
    end
    if (!cs_n && tx_ready) ready_viol <= ready_viol + 1;
    if (cs_n) begin
      high_run <= high_run + 1;
      if (!p_cs) begin
        last_low   <= cur_low;
        last_rises <= cur_rises;
        last_bits  <= cur_bits;
      end
    end
    if (rx_valid) rxv_count <= rxv_count + 1;
    if (mosi !== p_mosi && !(p_sclk && !sclk) && !(p_cs && !cs_n)) mosi_viol <= mosi_viol + 1;
    p_sclk <= sclk;
    p_cs   <= cs_n;
    p_mosi <= mosi;
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok       = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_rx(output logic [7:0] d, output bit ok, output bit single);
    ok = 1'b0;
    d  = 8'h00;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (rx_valid) begin
        ok = 1'b1;
        d  = rx_data;
        break;
      end
    end
    @(negedge clk);
    single = !rx_valid;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tx_valid_b = 1'b0; tx_data_b = 8'h00;
    repeat (3) @(negedge clk);
    n_total++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_n); else n_pass++;
    n_total++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else n_pass++;
    n_total++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi); else n_pass++;
    n_total++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b want 0", tx_ready); else n_pass++;
    n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
    n_total++; if (cs_n_b !== 1'b1) $display("FAIL reset_cs_n_b: got %b want 1", cs_n_b); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_total++; if (tx_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", tx_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (tx_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", tx_ready); else n_pass++;
  endtask

  task automatic test_loopback_a5;
    bit ok, single;
    logic [7:0] d;
    mode = 0;
    send_byte(8'hA5, ok);
    n_total++; if (!ok) $display("FAIL a5_accept: got timeout want accept"); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL a5_busy: got %b want 1", busy); else n_pass++;
    wait_rx(d, ok, single);
    n_total++; if (!ok) $display("FAIL a5_rx_valid: got timeout want pulse"); else n_pass++;
    n_total++; if (d !== 8'hA5) $display("FAIL a5_rx_data: got %h want a5", d); else n_pass++;
    n_total++; if (!single) $display("FAIL a5_pulse_width: got >1 cycle want 1"); else n_pass++;
    n_total++; if (last_low !== 49) $display("FAIL a5_cs_low: got %0d want 49", last_low); else n_pass++;
    n_total++; if (last_rises !== 8) $display("FAIL a5_sclk_rises: got %0d want 8", last_rises); else n_pass++;
    n_total++; if (last_bits !== 8'hA5) $display("FAIL a5_mosi_bits: got %h want a5", last_bits); else n_pass++;
    repeat (10) @(negedge clk);
    n_total++; if (rx_data !== 8'hA5) $display("FAIL a5_rx_hold: got %h want a5", rx_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL a5_busy_idle: got %b want 0", busy); else n_pass++;
    n_total++; if (tx_ready !== 1'b1) $display("FAIL a5_ready_idle: got %b want 1", tx_ready); else n_pass++;
  endtask

  task automatic test_const_miso;
    bit ok, single;
    logic [7:0] d;
    mode = 1; preset = 8'hFF;
    send_byte(8'h00, ok);
    wait_rx(d, ok, single);
    n_total++; if (!ok || d !== 8'hFF) $display("FAIL miso_one: got %h (ok=%0d) want ff", d, ok); else n_pass++;
    preset = 8'h00;
    send_byte(8'hFF, ok);
    wait_rx(d, ok, single);
    n_total++; if (!ok || d !== 8'h00) $display("FAIL miso_zero: got %h (ok=%0d) want 00", d, ok); else n_pass++;
  endtask

  task automatic test_echo;
    bit ok, single;
    logic [7:0] d;
    logic [7:0] seq [5];
    seq = '{8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h00};
    mode = 2;
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i], ok);
      wait_rx(d, ok, single);
      if (i > 0) begin
        n_total++;
        if (!ok || d !== seq[i-1]) $display("FAIL echo_%0d: got %h (ok=%0d) want %h", i, d, ok, seq[i-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random;
    bit ok, single;
    logic [7:0] d, b, exp;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      if (i % 2 == 0) begin
        mode = 0; exp = b;
      end else begin
        mode = 1; preset = 8'($urandom); exp = preset;
      end
      send_byte(b, ok);
      wait_rx(d, ok, single);
      n_total++; if (!ok || d !== exp) $display("FAIL rand_rx_%0d: got %h (ok=%0d) want %h", i, d, ok, exp); else n_pass++;
      n_total++; if (last_bits !== b) $display("FAIL rand_mosi_%0d: got %h want %h", i, last_bits, b); else n_pass++;
      n_total++; if (last_low !== 49) $display("FAIL rand_cs_low_%0d: got %0d want 49", i, last_low); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    bit ok, single, seen;
    logic [7:0] d;
    int falls0;
    mode = 0;
    falls0 = cs_falls;
    tx_data = 8'h3C; tx_valid = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx_ready) begin seen = 1'b1; break; end
    end
    @(posedge clk);
    #1 tx_data = 8'hC3;
    wait_rx(d, ok, single);
    n_total++; if (!seen || !ok || d !== 8'h3C) $display("FAIL b2b_first: got %h (ok=%0d) want 3c", d, ok); else n_pass++;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx_ready) begin seen = 1'b1; break; end
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_rx(d, ok, single);
    n_total++; if (!seen || !ok || d !== 8'hC3) $display("FAIL b2b_second: got %h (ok=%0d) want c3", d, ok); else n_pass++;
    n_total++; if (last_high !== 6) $display("FAIL b2b_cs_high: got %0d want 6", last_high); else n_pass++;
    repeat (100) @(negedge clk);
    n_total++; if (cs_falls - falls0 !== 2) $display("FAIL b2b_count: got %0d want 2", cs_falls - falls0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit ok, single, seen;
    logic [7:0] d;
    int rxv0;
    mode = 0;
    rxv0 = rxv_count;
    tx_data = 8'hFF; tx_valid = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (tx_valid && !cs_n) tx_valid = 1'b0;
      if (cur_rises == 4 && !cs_n) begin seen = 1'b1; break; end
    end
    tx_valid = 1'b0;
    n_total++; if (!seen) $display("FAIL mid_rise4: got timeout want 4 rises"); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (cs_n !== 1'b1) $display("FAIL mid_cs_n: got %b want 1", cs_n); else n_pass++;
    n_total++; if (sclk !== 1'b0) $display("FAIL mid_sclk: got %b want 0", sclk); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL mid_rx_data: got %h want 00", rx_data); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (80) @(negedge clk);
    #1;
    n_total++; if (rxv_count !== rxv0) $display("FAIL mid_no_rx_valid: got %0d pulses want 0", rxv_count - rxv0); else n_pass++;
    send_byte(8'h5A, ok);
    wait_rx(d, ok, single);
    n_total++; if (!ok || d !== 8'h5A) $display("FAIL mid_after: got %h (ok=%0d) want 5a", d, ok); else n_pass++;
    n_total++; if (last_low !== 49) $display("FAIL mid_after_cs_low: got %0d want 49", last_low); else n_pass++;
  endtask

  task automatic test_clkdiv2;
    bit seen;
    int low, rises;
    logic ps, rxv;
    logic [7:0] d;
    tx_data_b = 8'h81; tx_valid_b = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx_ready_b) begin seen = 1'b1; break; end
    end
    @(posedge clk);
    #1 tx_valid_b = 1'b0;
    low = 0; rises = 0; ps = 1'b0; rxv = 1'b0; d = 8'h00;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cs_n_b) begin rxv = rx_valid_b; d = rx_data_b; break; end
      low++;
      if (sclk_b && !ps) rises++;
      ps = sclk_b;
    end
    n_total++; if (!seen) $display("FAIL div2_accept: got timeout want accept"); else n_pass++;
    n_total++; if (low !== 33) $display("FAIL div2_cs_low: got %0d want 33", low); else n_pass++;
    n_total++; if (rises !== 8) $display("FAIL div2_rises: got %0d want 8", rises); else n_pass++;
    n_total++; if (rxv !== 1'b1 || d !== 8'h81) $display("FAIL div2_rx: got %h (valid=%b) want 81", d, rxv); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_loopback_a5;
    test_const_miso;
    test_echo;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_clkdiv2;
    n_total++; if (mosi_viol !== 0) $display("FAIL mosi_stability: got %0d changes want 0", mosi_viol); else n_pass++;
    n_total++; if (ready_viol !== 0) $display("FAIL ready_during_xfer: got %0d cycles want 0", ready_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

endmodule
